// File: rtl/burst_write_ctrl_pkg.sv
// Shared definitions for the burst write controller: FSM states and datapath widths.
package burst_write_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned LEN_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/burst_write_ctrl_addr_inc3.sv
// 3-bit address register: load takes priority over increment; increment wraps 7 -> 0.
module addr_inc3
  import burst_write_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] val_o
);

  logic [ADDR_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (inc_i) begin
      val_d = val_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/burst_write_ctrl.sv
// Burst write controller: turns a (start address, length) request plus a stream of
// valid/ready data beats into one-cycle register write strobes at consecutive addresses.
module burst_write_ctrl
  import burst_write_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic [ADDR_W-1:0] Addr,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              addr_load, addr_inc;
  logic [ADDR_W-1:0] cur_addr;

  addr_inc3 u_cur_addr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (addr_load),
    .load_val_i (req_addr),
    .inc_i      (addr_inc),
    .val_o      (cur_addr)
  );

  // Only WRITE accepts beats; decoded straight from the state register.
  assign din_ready = (state_q == WRITE);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    done_d       = 1'b0;
    addr_load    = 1'b0;
    addr_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_load    = 1'b1;
          beats_left_d = req_len;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        if (din_valid && din_ready) begin
          we_d     = 1'b1;
          addr_d   = cur_addr;
          wdata_d  = din;
          addr_inc = 1'b1;
          if (beats_left_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            beats_left_d = beats_left_q - LEN_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign Addr  = addr_q;
  assign wdata = wdata_q;
  assign we    = we_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule
